alu64_sequencer: RTL and testbench

Initiator for the registered 32-bit ALU: accepts 64-bit operation requests over a valid/ready handshake, issues two chained 32-bit ALU passes (low word, then high word), captures the registered ALU results, and returns a 64-bit result plus flag over a second valid/ready handshake. It sits between the datapath control and one ALU32 instance and owns that ALU's input ports exclusively.

---
 rtl/alu64_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_alu64_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu64_sequencer.sv
// Runs a 64-bit request on a 32-bit registered ALU as two chained passes, low word then high word.
// Returns the combined result and a flag over a valid/ready handshake.
module alu64_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic        in_cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_flag,
    output logic        out_err,
    output logic [2:0]  alu_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_cin,
    input  logic [31:0] alu_sum,
    input  logic        alu_cout
);

    typedef enum logic [2:0] {IDLE, WAIT_LO, CAP_LO, WAIT_HI, CAP_HI, DONE} state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LTU  = 3'b011;
    localparam logic [2:0] OP_EQ   = 3'b100;
    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_EQ  = 3'b100;
    localparam logic [2:0] SEL_NOP = 3'b111;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
    } drive_t;

    localparam drive_t IDLE_DRIVE = '{sel: SEL_NOP, a: 32'd0, b: 32'd0, cin: 1'b0};

    // carry is in_cin on the low pass and the captured low-word carry on the high pass
    function automatic drive_t word_drive(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic lo_pass,
                                          input logic carry);
        drive_t d;
        d = IDLE_DRIVE;
        case (op)
            OP_ADD: begin
                d.sel = SEL_ADD; d.a = a; d.b = b; d.cin = carry;
            end
            OP_SUB, OP_LTU: begin
                d.sel = SEL_ADD; d.a = a; d.b = ~b; d.cin = lo_pass ? 1'b1 : carry;
            end
            OP_SHL: begin
                d.sel = SEL_ADD; d.a = a; d.b = a; d.cin = lo_pass ? 1'b0 : carry;
            end
            OP_EQ: begin
                d.sel = SEL_EQ; d.a = a; d.b = b; d.cin = 1'b0;
            end
            default: d = IDLE_DRIVE;
        endcase
        return d;
    endfunction

    state_t      state_reg, state_next;
    logic [2:0]  op_reg;
    logic [31:0] a_hi_reg, b_hi_reg, lo_res_reg;
    logic        c_lo_reg;
    drive_t      drive_reg, drive_next;
    logic        in_ready_reg, in_ready_next;
    logic        out_valid_reg, out_valid_next;
    logic [63:0] out_data_reg, out_data_next;
    logic        out_flag_reg, out_flag_next;
    logic        out_err_reg, out_err_next;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = WAIT_LO;
            WAIT_LO: state_next = CAP_LO;
            CAP_LO:  state_next = WAIT_HI;
            WAIT_HI: state_next = CAP_HI;
            CAP_HI:  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Computes the next value of every registered output from the current state.
    always_comb begin
        drive_next     = drive_reg;
        out_data_next  = out_data_reg;
        out_flag_next  = out_flag_reg;
        out_err_next   = out_err_reg;
        in_ready_next  = (state_next == IDLE);
        out_valid_next = (state_next == DONE);
        case (state_reg)
            IDLE: if (in_valid)
                drive_next = word_drive(in_op, in_a[31:0], in_b[31:0], 1'b1, in_cin);
            CAP_LO:
                drive_next = word_drive(op_reg, a_hi_reg, b_hi_reg, 1'b0, alu_cout);
            CAP_HI: begin
                drive_next   = IDLE_DRIVE;
                out_err_next = 1'b0;
                case (op_reg)
                    OP_ADD, OP_SUB: begin
                        out_data_next = {alu_sum, lo_res_reg};
                        out_flag_next = alu_cout;
                    end
                    OP_SHL: begin
                        out_data_next = {alu_sum, lo_res_reg};
                        out_flag_next = a_hi_reg[31];
                    end
                    OP_LTU: begin
                        out_data_next = {alu_sum, lo_res_reg};
                        out_flag_next = ~alu_cout;
                    end
                    OP_EQ: begin
                        out_data_next = 64'd0;
                        out_flag_next = c_lo_reg & alu_cout;
                    end
                    default: begin
                        out_data_next = 64'd0;
                        out_flag_next = 1'b0;
                        out_err_next  = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg        <= 3'd0;
            a_hi_reg      <= 32'd0;
            b_hi_reg      <= 32'd0;
            lo_res_reg    <= 32'd0;
            c_lo_reg      <= 1'b0;
            drive_reg     <= IDLE_DRIVE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 64'd0;
            out_flag_reg  <= 1'b0;
            out_err_reg   <= 1'b0;
        end else begin
            if (state_reg == IDLE && in_valid) begin
                op_reg   <= in_op;
                a_hi_reg <= in_a[63:32];
                b_hi_reg <= in_b[63:32];
            end
            if (state_reg == CAP_LO) begin
                lo_res_reg <= alu_sum;
                c_lo_reg   <= alu_cout;
            end
            drive_reg     <= drive_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_flag_reg  <= out_flag_next;
            out_err_reg   <= out_err_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_flag  = out_flag_reg;
    assign out_err   = out_err_reg;
    assign alu_sel   = drive_reg.sel;
    assign alu_a     = drive_reg.a;
    assign alu_b     = drive_reg.b;
    assign alu_cin   = drive_reg.cin;

endmodule

// File: tb/tb_alu64_sequencer.sv
// Bench for alu64_sequencer: a registered ALU32 stand-in, a 64-bit arithmetic reference model
// checked every cycle, and directed requests with hand-computed results.
module tb_alu64_sequencer;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_cin, out_valid, out_ready;
    logic [2:0]  in_op, alu_sel;
    logic [63:0] in_a, in_b, out_data;
    logic        out_flag, out_err, alu_cin, alu_cout;
    logic [31:0] alu_a, alu_b, alu_sum;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    alu64_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_flag(out_flag), .out_err(out_err),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_sum(alu_sum), .alu_cout(alu_cout)
    );

    // Registered ALU32: 000 adds with carry, 100 compares for equality.
    always @(posedge clk) begin
        if (rst) begin
            alu_sum <= 32'd0; alu_cout <= 1'b0;
        end else if (alu_sel == 3'b000) begin
            {alu_cout, alu_sum} <= {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
        end else if (alu_sel == 3'b100) begin
            alu_sum <= 32'd0; alu_cout <= (alu_a == alu_b);
        end else begin
            alu_sum <= 32'd0; alu_cout <= 1'b0;
        end
    end

    // {err, flag, data} straight from 64-bit arithmetic.
    function automatic logic [65:0] ref_result(input logic [2:0] op, input logic [63:0] a,
                                               input logic [63:0] b, input logic cin);
        logic [64:0] s;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b} + {64'd0, cin};
                return {1'b0, s[64], s[63:0]};
            end
            3'd1: return {1'b0, a >= b, a - b};
            3'd2: return {1'b0, a[63], a << 1};
            3'd3: return {1'b0, a < b, a - b};
            3'd4: return {1'b0, a == b, 64'd0};
            default: return {1'b1, 1'b0, 64'd0};
        endcase
    endfunction

    // Model: 0 idle, 1..4 cycles in flight, 5 response pending.
    int          m_phase;
    logic [2:0]  m_op;
    logic [63:0] m_a, m_data;
    logic        m_flag, m_err;
    logic [65:0] m_pend;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0; m_data <= 64'd0; m_flag <= 1'b0; m_err <= 1'b0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_phase <= 1; m_op <= in_op; m_a <= in_a;
                m_pend  <= ref_result(in_op, in_a, in_b, in_cin);
            end
        end else if (m_phase < 4) begin
            m_phase <= m_phase + 1;
        end else if (m_phase == 4) begin
            m_phase <= 5;
            {m_err, m_flag, m_data} <= m_pend;
        end else if (out_ready) begin
            m_phase <= 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", 64'(in_ready), 64'(m_phase == 0));
            chk("out_valid", 64'(out_valid), 64'(m_phase == 5));
            chk("out_data", out_data, m_data);
            chk("out_flag", 64'(out_flag), 64'(m_flag));
            chk("out_err", 64'(out_err), 64'(m_err));
            if (m_phase == 0 || m_phase == 5 || m_op > 3'd4) begin
                chk("alu_sel_idle", 64'(alu_sel), 64'd7);
                chk("alu_a_idle", 64'(alu_a), 64'd0);
            end else begin
                chk("alu_a_pass", 64'(alu_a), 64'(m_phase <= 2 ? m_a[31:0] : m_a[63:32]));
            end
        end
    end

    task automatic do_req(input string name, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic cin, input logic [63:0] e_data,
                          input logic e_flag, input logic e_err, output int waits);
        int lat;
        in_op = op; in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        waits = 0;
        while (!in_ready && waits < 20) begin
            @(negedge clk); waits++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL %s accept timeout", name);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_a = ~a; in_b = ~b; in_op = 3'b101;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk); lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'd4);
        chk({name, "_data"}, out_data, e_data);
        chk({name, "_flag"}, 64'(out_flag), 64'(e_flag));
        chk({name, "_err"}, 64'(out_err), 64'(e_err));
        $display("txn %s op=%0d a=%h b=%h -> data=%h flag=%0d err=%0d lat=%0d",
                 name, op, a, b, out_data, out_flag, out_err, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = 64'd0; in_b = 64'd0;
        in_cin = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_alu_sel", 64'(alu_sel), 64'd7);
        cmp_en = 1'b1;

        do_req("add_wrap", 3'd0, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, w);
        do_req("add_cin", 3'd0, 64'h00000000_FFFFFFFF, 64'd0, 1'b1, 64'h00000001_00000000, 1'b0, 1'b0, w);
        do_req("sub", 3'd1, 64'h00000001_00000000, 64'd1, 1'b0, 64'h00000000_FFFFFFFF, 1'b1, 1'b0, w);
        do_req("ltu", 3'd3, 64'd5, 64'h00000001_00000000, 1'b0, 64'hFFFFFFFF_00000005, 1'b1, 1'b0, w);
        do_req("shl", 3'd2, 64'h80000000_80000000, 64'd0, 1'b0, 64'h00000001_00000000, 1'b1, 1'b0, w);
        do_req("eq_same", 3'd4, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0, 64'd0, 1'b1, 1'b0, w);
        do_req("eq_diff", 3'd4, 64'h12345678_9ABCDEF0, 64'h12345679_9ABCDEF0, 1'b0, 64'd0, 1'b0, 1'b0, w);
        do_req("illegal", 3'd6, 64'h1111, 64'h2222, 1'b1, 64'd0, 1'b0, 1'b1, w);

        // Backpressure: response held three cycles with a new request waiting.
        @(negedge clk);
        out_ready = 1'b0;
        do_req("bp_add", 3'd0, 64'd10, 64'd20, 1'b0, 64'd30, 1'b0, 1'b0, w);
        in_op = 3'd1; in_a = 64'd3; in_b = 64'd5; in_cin = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_data", out_data, 64'd30);
        end
        out_ready = 1'b1;
        do_req("bp_sub", 3'd1, 64'd3, 64'd5, 1'b0, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0, w);
        chk("bp_accept_gap", 64'(w), 64'd1);

        // Reset while the low pass is being captured.
        @(negedge clk);
        in_op = 3'd0; in_a = 64'd7; in_b = 64'd8; in_cin = 1'b0; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk); w++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_out_data", out_data, 64'd0);
        chk("rst_mid_alu_sel", 64'(alu_sel), 64'd7);
        repeat (6) begin
            @(negedge clk);
            chk("rst_no_resp", 64'(out_valid), 64'd0);
        end
        do_req("post_rst_add", 3'd0, 64'd2, 64'd3, 1'b0, 64'd5, 1'b0, 1'b0, w);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
